// File: rtl/ufix_divider_seq_if.sv
// rtl/ufix_divider_seq_if.sv - operand/result handshake bundle for ufix_divider_seq
interface ufix_divider_seq_if #(
  parameter int WIDTH = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic             ovf;
  logic             dvz;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, q, ovf, dvz
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, q, ovf, dvz
  );
endinterface

// File: rtl/ufix_divider_seq.sv
// rtl/ufix_divider_seq.sv - sequential restoring divider for unsigned fixed-point operands
// Optional round-half-up via UFIX_DIV_ROUND_EN (one extra guard iteration).
module ufix_divider_seq #(
  parameter int WIDTH = 10,
  parameter int FRAC  = 4
) (
  input logic              clk,
  input logic              rst,
  ufix_divider_seq_if.slave bus
);
`ifdef UFIX_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int N  = WIDTH + FRAC;
  localparam int NI = N + RND;
  localparam int CW = $clog2(NI + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] b_reg;
  logic [NI-1:0]    dvd;
  logic [NI-1:0]    quo;
  logic [WIDTH-1:0] q_r;
  logic             ovf_r;
  logic             dvz_r;
  logic             in_ready_w;
  logic             out_valid_w;
  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   r_sub;
  logic             qbit;
  logic [NI-1:0]    quo_nx;
  logic [N-1:0]     q_trunc;
  logic [WIDTH-1:0] q_fin;
  logic             ovf_fin;
`ifdef UFIX_DIV_ROUND_EN
  logic             guard;
  logic             carry;
  logic [WIDTH-1:0] q_inc;
`endif

  assign accept    = bus.in_valid && in_ready_w;
  assign last_iter = (cnt == CW'(NI - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    in_ready_w  = 1'b0;
    out_valid_w = 1'b0;
    case (state)
      IDLE: begin
        in_ready_w = 1'b1;
        if (bus.in_valid) state_nx = (bus.b_in == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_iter) state_nx = DONE;
      end
      DONE: begin
        out_valid_w = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    r_shift = {rem[WIDTH-1:0], dvd[NI-1]};
    qbit    = (r_shift >= {1'b0, b_reg});
    r_sub   = r_shift - {1'b0, b_reg};
    quo_nx  = {quo[NI-2:0], qbit};
  end

  // Final result formatting, evaluated on the last iteration's quotient.
  always_comb begin
`ifdef UFIX_DIV_ROUND_EN
    q_trunc        = quo_nx[NI-1:1];
    guard          = quo_nx[0];
    {carry, q_inc} = {1'b0, q_trunc[WIDTH-1:0]} + (WIDTH + 1)'(guard);
    ovf_fin        = ((q_trunc >> WIDTH) != '0) || carry;
    q_fin          = ovf_fin ? '1 : q_inc;
`else
    q_trunc = quo_nx;
    ovf_fin = ((q_trunc >> WIDTH) != '0);
    q_fin   = ovf_fin ? '1 : q_trunc[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      rem   <= '0;
      b_reg <= '0;
      dvd   <= '0;
      quo   <= '0;
      q_r   <= '0;
      ovf_r <= 1'b0;
      dvz_r <= 1'b0;
    end else if (accept) begin
      b_reg <= bus.b_in;
      dvd   <= NI'(bus.a_in) << (NI - WIDTH);
      rem   <= '0;
      quo   <= '0;
      cnt   <= '0;
      if (bus.b_in == '0) begin
        q_r   <= '1;
        ovf_r <= 1'b0;
        dvz_r <= 1'b1;
      end
    end else if (state == RUN) begin
      rem <= qbit ? r_sub : r_shift;
      dvd <= dvd << 1;
      quo <= quo_nx;
      cnt <= cnt + CW'(1);
      if (last_iter) begin
        q_r   <= q_fin;
        ovf_r <= ovf_fin;
        dvz_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.q         = q_r;
  assign bus.ovf       = ovf_r;
  assign bus.dvz       = dvz_r;
endmodule

// File: tb/tb_ufix_divider_seq.sv
// tb/tb_ufix_divider_seq.sv - directed vector bench for ufix_divider_seq (WIDTH=10, FRAC=4)
module tb_ufix_divider_seq;
  localparam int WIDTH = 10;
  localparam int FRAC  = 4;
  localparam int N     = WIDTH + FRAC;
`ifdef UFIX_DIV_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] q_t;
    logic [9:0] q_r;
    logic       ovf;
    logic       dvz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  vec_t vecs[11];

  always #5 clk = ~clk;

  ufix_divider_seq_if #(.WIDTH(WIDTH)) bus ();
  ufix_divider_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic run_op(input logic [9:0] a, input logic [9:0] b, output int lat);
    @(negedge clk);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.in_valid = 1'b1;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic release_op();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int exp_lat;
    vecs[0]  = '{10'h030, 10'h018, 10'h020, 10'h020, 1'b0, 1'b0};
    vecs[1]  = '{10'h010, 10'h060, 10'h002, 10'h003, 1'b0, 1'b0};
    vecs[2]  = '{10'h3FF, 10'h001, 10'h3FF, 10'h3FF, 1'b1, 1'b0};
    vecs[3]  = '{10'h000, 10'h055, 10'h000, 10'h000, 1'b0, 1'b0};
    vecs[4]  = '{10'h123, 10'h000, 10'h3FF, 10'h3FF, 1'b0, 1'b1};
    vecs[5]  = '{10'h3FF, 10'h3FF, 10'h010, 10'h010, 1'b0, 1'b0};
    vecs[6]  = '{10'h001, 10'h3FF, 10'h000, 10'h000, 1'b0, 1'b0};
    vecs[7]  = '{10'h0A0, 10'h030, 10'h035, 10'h035, 1'b0, 1'b0};
    vecs[8]  = '{10'h040, 10'h001, 10'h3FF, 10'h3FF, 1'b1, 1'b0};
    vecs[9]  = '{10'h03F, 10'h001, 10'h3F0, 10'h3F0, 1'b0, 1'b0};
    vecs[10] = '{10'h3FF, 10'h011, 10'h3C2, 10'h3C3, 1'b0, 1'b0};

    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_q", 32'(bus.q), 32'd0);
    chk("reset_ovf", 32'(bus.ovf), 32'd0);
    chk("reset_dvz", 32'(bus.dvz), 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      // Divide-by-zero enters DONE on the accept edge itself.
      exp_lat = vecs[i].dvz ? 0 : N + int'(RND);
      chk($sformatf("lat[%0d]", i), 32'(lat), 32'(exp_lat));
      chk($sformatf("q[%0d]", i), 32'(bus.q), 32'(RND ? vecs[i].q_r : vecs[i].q_t));
      chk($sformatf("ovf[%0d]", i), 32'(bus.ovf), 32'(vecs[i].ovf));
      chk($sformatf("dvz[%0d]", i), 32'(bus.dvz), 32'(vecs[i].dvz));
      chk($sformatf("in_ready_done[%0d]", i), 32'(bus.in_ready), 32'd0);
      release_op();
    end

    // Backpressure: results held, competing operands ignored, no accept on release.
    run_op(10'h030, 10'h018, lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a_in     = 10'h3FF;
      bus.b_in     = 10'h001;
      @(posedge clk);
      #1;
      chk($sformatf("bp_out_valid[%0d]", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_in_ready[%0d]", c), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp_q[%0d]", c), 32'(bus.q), 32'h020);
      chk($sformatf("bp_ovf[%0d]", c), 32'(bus.ovf), 32'd0);
      chk($sformatf("bp_dvz[%0d]", c), 32'(bus.dvz), 32'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset during RUN aborts the operation.
    @(negedge clk);
    bus.a_in     = 10'h030;
    bus.b_in     = 10'h018;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_q", 32'(bus.q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(10'h010, 10'h060, lat);
    chk("post_abort_lat", 32'(lat), 32'(N + int'(RND)));
    chk("post_abort_q", 32'(bus.q), RND ? 32'h003 : 32'h002);
    chk("post_abort_ovf", 32'(bus.ovf), 32'd0);
    release_op();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
